// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the seven-segment display controller.
package seg_display_ctrl_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic {IDLE, CONV} state_t;

   // BCD digits needed to hold 2^width-1
   function automatic int unsigned bcd_digits(input int unsigned width);
      return (width + 2) / 3;
   endfunction

endpackage

// File: rtl/seg_display_ctrl_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern, with dash and blank overrides.
module seg7_decode
   import seg_display_ctrl_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg_c
);

   // Dash wins over blank; non-decimal codes render blank
   always_comb begin
      seg_c = SEG_BLANK;
      if (dash) begin
         seg_c = SEG_DASH;
      end else if (!blank) begin
         case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: sequential double-dabble conversion plus
// free-running digit scan. Define SEG_BLANK_EN for leading-zero blanking.
module seg_display_ctrl
   import seg_display_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DIGITS   = 3,
   parameter int unsigned SCAN_DIV = 1000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WIDTH-1:0]  value,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int unsigned NB = bcd_digits(WIDTH);
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned XW = 4 * (NB + DIGITS);

   state_t             state, state_n;
   logic               accept_c, commit_c;
   logic [CW-1:0]      step;
   logic [WIDTH-1:0]   bin_sh, bin_n_c;
   logic [4*NB-1:0]    bcd, adj_c, bcd_n_c;
   logic [XW-1:0]      bcd_x_c;
   logic [4*DIGITS-1:0] disp;
   logic [PW-1:0]      presc;
   logic [IW-1:0]      idx;
   logic [3:0]         digit_c;
   logic               blank_c;
   logic [6:0]         seg_c;

   // Conversion FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state: accept a load in IDLE, finish after WIDTH shift steps
   always_comb begin
      state_n  = state;
      accept_c = 1'b0;
      commit_c = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               accept_c = 1'b1;
               state_n  = CONV;
            end
         end
         CONV: begin
            if (step == CW'(WIDTH - 1)) begin
               commit_c = 1'b1;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left
   always_comb begin
      adj_c = '0;
      for (int i = 0; i < int'(NB); i++) begin
         adj_c[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      end
      {bcd_n_c, bin_n_c} = {adj_c, bin_sh} << 1;
      bcd_x_c = XW'(bcd_n_c);
   end

   // Conversion datapath, display register and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         step   <= '0;
         bin_sh <= '0;
         bcd    <= '0;
         disp   <= '0;
      end else begin
         done <= commit_c;
         if (accept_c) begin
            busy   <= 1'b1;
            step   <= '0;
            bin_sh <= value;
            bcd    <= '0;
         end else if (state == CONV) begin
            step   <= step + CW'(1);
            bin_sh <= bin_n_c;
            bcd    <= bcd_n_c;
            if (commit_c) begin
               busy <= 1'b0;
               disp <= bcd_x_c[4*DIGITS-1:0];
               ovf  <= |bcd_x_c[XW-1:4*DIGITS];
            end
         end
      end
   end

   // Free-running prescaler and digit index
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PW'(SCAN_DIV - 1)) begin
         presc <= '0;
         idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Select the scanned digit and decide whether it is a blanked leading zero
   always_comb begin
`ifdef SEG_BLANK_EN
      logic lead;
`endif
      digit_c = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (IW'(i) == idx) digit_c = disp[4*i +: 4];
      end
      blank_c = 1'b0;
`ifdef SEG_BLANK_EN
      lead = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         lead = lead && (disp[4*i +: 4] == 4'd0);
         if (IW'(i) == idx) blank_c = lead;
      end
`endif
   end

   seg7_decode u_decode (
      .digit (digit_c),
      .blank (blank_c),
      .dash  (ovf),
      .seg_c (seg_c)
   );

   // Registered segment bus and one-hot active-low digit enable
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_BLANK;
         an  <= '1;
      end else begin
         seg <= seg_c;
         an  <= ~(DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: a 3-digit and a 2-digit instance, SCAN_DIV=4.
module tb_seg_display_ctrl;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000, S9 = 7'b0010000;
   localparam logic [6:0] DASH = 7'b0111111, OFF = 7'h7F;
`ifdef SEG_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'b1000000;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load3 = 1'b0, load2 = 1'b0;
   logic [7:0] value3 = '0, value2 = '0;
   logic       busy3, done3, ovf3, busy2, done2, ovf2;
   logic [6:0] seg3, seg2;
   logic [2:0] an3;
   logic [1:0] an2;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   // Edges since reset released; gives the expected scan slot
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   seg_display_ctrl #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) u_dut3 (
      .clk(clk), .rst(rst), .load(load3), .value(value3),
      .busy(busy3), .done(done3), .ovf(ovf3), .seg(seg3), .an(an3));

   seg_display_ctrl #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) u_dut2 (
      .clk(clk), .rst(rst), .load(load2), .value(value2),
      .busy(busy2), .done(done2), .ovf(ovf2), .seg(seg2), .an(an2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic disp3(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                        input logic [6:0] d2);
      int         slot;
      logic [6:0] w;
      logic [2:0] wan;
      slot = ((cyc - 1) / 4) % 3;
      w    = (slot == 0) ? d0 : (slot == 1) ? d1 : d2;
      wan  = ~(3'b001 << slot);
      chk({tag, "_an3"}, 8'(an3), 8'(wan));
      chk({tag, "_seg3"}, 8'(seg3), 8'(w));
   endtask

   task automatic disp2(input string tag, input logic [6:0] d0, input logic [6:0] d1);
      int         slot;
      logic [1:0] wan;
      slot = ((cyc - 1) / 4) % 2;
      wan  = ~(2'b01 << slot);
      chk({tag, "_an2"}, 8'(an2), 8'(wan));
      chk({tag, "_seg2"}, 8'(seg2), 8'((slot == 0) ? d0 : d1));
   endtask

   // Load v into the selected instance; optionally pulse a second load during busy
   task automatic conv(input int sel, input logic [7:0] v, input int ign_at,
                       input logic [7:0] ign_v);
      if (sel == 0) begin load3 = 1'b1; value3 = v; end
      else          begin load2 = 1'b1; value2 = v; end
      tick();
      load3 = 1'b0; load2 = 1'b0;
      if (sel == 0) value3 = ~v; else value2 = ~v;
      for (int i = 0; i < 8; i++) begin
         chk("busy_hi", 8'((sel == 0) ? busy3 : busy2), 8'd1);
         chk("done_lo", 8'((sel == 0) ? done3 : done2), 8'd0);
         if (i == ign_at) begin
            if (sel == 0) begin load3 = 1'b1; value3 = ign_v; end
            else          begin load2 = 1'b1; value2 = ign_v; end
         end else begin
            load3 = 1'b0; load2 = 1'b0;
         end
         tick();
      end
      load3 = 1'b0; load2 = 1'b0;
      chk("busy_fall", 8'((sel == 0) ? busy3 : busy2), 8'd0);
      chk("done_pulse", 8'((sel == 0) ? done3 : done2), 8'd1);
      tick();
      chk("done_end", 8'((sel == 0) ? done3 : done2), 8'd0);
   endtask

   initial begin
      // Reset
      tick(); tick();
      chk("rst_busy", 8'(busy3), 8'd0);
      chk("rst_done", 8'(done3), 8'd0);
      chk("rst_ovf", 8'(ovf3), 8'd0);
      chk("rst_seg", 8'(seg3), 8'(OFF));
      chk("rst_an3", 8'(an3), 8'h07);
      chk("rst_an2", 8'(an2), 8'h03);
      rst = 1'b0;
      tick();
      chk("first_an3", 8'(an3), 8'h06);
      chk("first_seg3", 8'(seg3), 8'(S0));
      chk("first_an2", 8'(an2), 8'h02);
      chk("first_seg2", 8'(seg2), 8'(S0));
      for (int i = 0; i < 12; i++) begin disp3("idle0", S0, LZ, LZ); tick(); end

      // 255 -> 2 5 5
      conv(0, 8'd255, -1, 8'd0);
      chk("ovf_255", 8'(ovf3), 8'd0);
      for (int i = 0; i < 13; i++) begin disp3("v255", S5, S5, S2); tick(); end

      // Two-digit overflow, then recovery
      conv(1, 8'd200, -1, 8'd0);
      chk("ovf_200", 8'(ovf2), 8'd1);
      for (int i = 0; i < 9; i++) begin disp2("v200", DASH, DASH); tick(); end
      conv(1, 8'd42, -1, 8'd0);
      chk("ovf_42", 8'(ovf2), 8'd0);
      for (int i = 0; i < 9; i++) begin disp2("v42", S2, S4); tick(); end

      // Leading zeros
      conv(0, 8'd7, -1, 8'd0);
      for (int i = 0; i < 12; i++) begin disp3("v7", S7, LZ, LZ); tick(); end
      conv(0, 8'd0, -1, 8'd0);
      for (int i = 0; i < 12; i++) begin disp3("v0", S0, LZ, LZ); tick(); end

      // Load while busy is ignored
      conv(0, 8'd99, 2, 8'd17);
      chk("no_restart", 8'(busy3), 8'd0);
      for (int i = 0; i < 12; i++) begin disp3("v99", S9, S9, LZ); tick(); end
      conv(0, 8'd17, -1, 8'd0);
      for (int i = 0; i < 12; i++) begin disp3("v17", S7, S1, LZ); tick(); end

      // Reset aborts a conversion; load in the reset cycle loses
      load3 = 1'b1; value3 = 8'd123;
      tick();
      load3 = 1'b0;
      for (int i = 0; i < 3; i++) begin chk("abort_busy", 8'(busy3), 8'd1); tick(); end
      rst = 1'b1; load3 = 1'b1;
      tick();
      rst = 1'b0; load3 = 1'b0;
      chk("abort_busy0", 8'(busy3), 8'd0);
      chk("abort_done0", 8'(done3), 8'd0);
      chk("abort_ovf0", 8'(ovf3), 8'd0);
      chk("abort_an", 8'(an3), 8'h07);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("abort_nodone", 8'(done3), 8'd0);
         chk("abort_nobusy", 8'(busy3), 8'd0);
         disp3("abort", S0, LZ, LZ);
      end
      tick();

      // Normal conversion after abort
      conv(0, 8'd123, -1, 8'd0);
      for (int i = 0; i < 12; i++) begin disp3("v123", S3, S2, S1); tick(); end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
